alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: WORD_W, 32, width of ALU result word (matches regbits_t).
REQ-002 Parameter: DEPTH, 2, entry count; only value 2 is supported.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: nRST  in  1  reset, synchronous, active-low.
REQ-005 Port: flush  in  1  synchronous discard of all entries.
REQ-006 Port: in_valid  in  1  upstream ALU result valid this cycle.
REQ-007 Port: in_ready  out  1  buffer can accept an entry this cycle.
REQ-008 Port: port_out  in  WORD_W  ALU result.
REQ-009 Port: negative, zero, overflow  in  1 each  ALU flags.
REQ-010 Port: ov_trap  in  1  current op is signed-trapping (ADD/SUB).
REQ-011 Port: wsel  in  5  destination register index.
REQ-012 Port: wen  in  1  destination write enable.
REQ-013 Port: out_valid  out  1  head entry valid.
REQ-014 Port: out_ready  in  1  downstream consumes head this cycle.
REQ-015 Port: out_result  out  WORD_W  head result.
REQ-016 Port: out_negative, out_zero, out_overflow  out  1 each  head flags.
REQ-017 Port: out_wsel  out  5  head destination index.
REQ-018 Port: out_wen  out  1  head write enable after trap masking.
REQ-019 Port: out_exc  out  1  head entry raised an overflow exception.
REQ-020 Port: count  out  2  occupancy, 0..2.

Function
REQ-021 Buffer SHALL be a 2-entry FIFO: head pointer, tail pointer (1 bit each, wrap 1->0), 2-bit count.
REQ-022 in_ready SHALL equal (count != 2), from registered state only; no combinational path from out_ready.
REQ-023 Push SHALL occur when in_valid && in_ready && !flush; entry written at tail, tail toggles.
REQ-024 Pop SHALL occur when out_valid && out_ready && !flush; head toggles.
REQ-025 out_valid SHALL equal (count != 0); entry pushed in cycle N visible at outputs in cycle N+1 (latency 1).
REQ-026 Push and pop in same cycle SHALL leave count unchanged; at count 1 the new entry becomes head next cycle.
REQ-027 At count 2 in_valid SHALL be ignored; no overwrite.
REQ-028 At count 0 out_ready SHALL be ignored; count never underflows.
REQ-029 Trap rule at push: stored exc = overflow && ov_trap; stored wen = wen && !(overflow && ov_trap).
REQ-030 Flags, result, wsel SHALL be stored unmodified, including for trapped entries.
REQ-031 When count == 0, out_result, all out flags, out_wsel, out_wen, out_exc SHALL drive 0.
REQ-032 flush SHALL, at the next edge, set count, head, tail to 0; it has priority over simultaneous push and pop, and the pushed entry is dropped.
REQ-033 Outputs SHALL never change while out_valid && !out_ready, except via flush or reset.

Reset
REQ-034 nRST low at a rising edge SHALL set count=0, head=0, tail=0; entry storage need not be cleared.
REQ-035 After reset: out_valid=0, in_ready=1, count=0, all data outputs 0.
REQ-036 Reset asserted mid-operation SHALL discard all entries and have priority over flush, push, pop.

Verification
REQ-037 Single pass: push port_out=0x0000_0005, wsel=3, wen=1, out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_wsel=3, out_wen=1; following cycle count=0.
REQ-038 Fill/backpressure: out_ready=0, push 0xA then 0xB -> count=2, in_ready=0; third push 0xC ignored; raise out_ready -> outputs 0xA then 0xB, never 0xC.
REQ-039 Simultaneous: count=1 holding 0x1, push 0x2 with out_ready=1 -> count stays 1, next head 0x2; then count=0.
REQ-040 Trap: port_out=0x8000_0000, overflow=1, ov_trap=1, wen=1 -> out_wen=0, out_exc=1, out_overflow=1; same with ov_trap=0 -> out_wen=1, out_exc=0.
REQ-041 Flush: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, data outputs 0.
REQ-042 Reset mid-stream: count=2, nRST=0 for one edge -> count=0, out_valid=0; first push after release appears at out_result one cycle later.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Two-entry FIFO that decouples the ALU result stage from its consumer.
// Each entry holds the ALU result word, its flags, the destination register
// index and a write enable. For signed-trapping ops (ADD/SUB) that overflow,
// the write enable is suppressed and an exception bit is recorded instead.
//
// Ports
//   CLK          in   single clock, rising edge
//   nRST         in   synchronous active-low reset
//   flush        in   discard all entries at the next edge (drops a push)
//   in_valid     in   upstream result valid
//   in_ready     out  buffer not full (registered state only)
//   port_out     in   ALU result word
//   negative, zero, overflow  in  ALU flags
//   ov_trap      in   current op traps on signed overflow
//   wsel         in   destination register index
//   wen          in   destination write enable
//   out_valid    out  head entry valid
//   out_ready    in   consumer takes head this cycle
//   out_result, out_negative, out_zero, out_overflow, out_wsel  out  head data
//   out_wen      out  head write enable after trap masking
//   out_exc      out  head raised an overflow exception
//   count        out  occupancy 0..2
// All data outputs read 0 while the buffer is empty.

module alu_result_buffer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] port_out,
  input  logic              negative,
  input  logic              zero,
  input  logic              overflow,
  input  logic              ov_trap,
  input  logic [4:0]        wsel,
  input  logic              wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_negative,
  output logic              out_zero,
  output logic              out_overflow,
  output logic [4:0]        out_wsel,
  output logic              out_wen,
  output logic              out_exc,
  output logic [1:0]        count
);

  // Only a two-entry buffer is supported; pointers are single bits.
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  // Overflow exception is raised only for trapping ops.
  function automatic logic trap_exc(input logic ovf, input logic trap);
    return ovf & trap;
  endfunction

  // A trapped op must not update the register file.
  function automatic logic masked_wen(input logic we, input logic ovf, input logic trap);
    return we & ~trap_exc(ovf, trap);
  endfunction

  logic [WORD_W-1:0] result_r [2];
  logic [1:0]        neg_r;
  logic [1:0]        zero_r;
  logic [1:0]        ovf_r;
  logic [4:0]        wsel_r [2];
  logic [1:0]        wen_r;
  logic [1:0]        exc_r;

  logic       head_r;
  logic       tail_r;
  logic [1:0] count_r;

  logic push_s;
  logic pop_s;

  assign in_ready  = (count_r != FULL_CNT);
  assign out_valid = (count_r != 2'd0);
  assign count     = count_r;

  assign push_s = in_valid & in_ready & ~flush;
  assign pop_s  = out_valid & out_ready & ~flush;

  // Pointer and occupancy state; reset beats flush, flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (flush) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        tail_r <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; written only on an accepted push, never cleared.
  always_ff @(posedge CLK) begin
    if (push_s && nRST) begin
      result_r[tail_r] <= port_out;
      neg_r[tail_r]    <= negative;
      zero_r[tail_r]   <= zero;
      ovf_r[tail_r]    <= overflow;
      wsel_r[tail_r]   <= wsel;
      wen_r[tail_r]    <= masked_wen(wen, overflow, ov_trap);
      exc_r[tail_r]    <= trap_exc(overflow, ov_trap);
    end
  end

  // Head read-out from registered state, forced to zero when empty.
  always_comb begin
    out_result   = '0;
    out_negative = 1'b0;
    out_zero     = 1'b0;
    out_overflow = 1'b0;
    out_wsel     = 5'd0;
    out_wen      = 1'b0;
    out_exc      = 1'b0;
    if (out_valid) begin
      out_result   = result_r[head_r];
      out_negative = neg_r[head_r];
      out_zero     = zero_r[head_r];
      out_overflow = ovf_r[head_r];
      out_wsel     = wsel_r[head_r];
      out_wen      = wen_r[head_r];
      out_exc      = exc_r[head_r];
    end else begin
      out_result   = '0;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  typedef struct packed {
    logic [31:0] res;
    logic        neg;
    logic        zer;
    logic        ovf;
    logic        trap;
    logic [4:0]  wsel;
    logic        wen;
  } stim_t;

  typedef struct packed {
    logic [31:0] res;
    logic        neg;
    logic        zer;
    logic        ovf;
    logic [4:0]  wsel;
    logic        wen;
    logic        exc;
  } exp_t;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] port_out;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        ov_trap;
  logic [4:0]  wsel;
  logic        wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_negative;
  logic        out_zero;
  logic        out_overflow;
  logic [4:0]  out_wsel;
  logic        out_wen;
  logic        out_exc;
  logic [1:0]  count;

  int vectors_applied;
  int miscompares;
  exp_t exp_q[$];

  alu_result_buffer #(.WORD_W(32), .DEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .port_out(port_out), .negative(negative), .zero(zero),
    .overflow(overflow), .ov_trap(ov_trap), .wsel(wsel), .wen(wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_negative(out_negative),
    .out_zero(out_zero), .out_overflow(out_overflow),
    .out_wsel(out_wsel), .out_wen(out_wen), .out_exc(out_exc),
    .count(count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] r, input logic [4:0] ws, input logic we,
                               input logic ov, input logic tr);
    stim_t s;
    s.res  = r;
    s.neg  = r[31];
    s.zer  = (r == 32'd0);
    s.ovf  = ov;
    s.trap = tr;
    s.wsel = ws;
    s.wen  = we;
    return s;
  endfunction

  // Compare all outputs against the scoreboard head.
  task automatic check_outputs(input string tag);
    exp_t e;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() != 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    e = '0;
    if (exp_q.size() != 0) e = exp_q[0];
    check({tag, ".out_result"}, 64'(out_result), 64'(e.res));
    check({tag, ".flags"}, 64'({out_negative, out_zero, out_overflow}),
          64'({e.neg, e.zer, e.ovf}));
    check({tag, ".out_wsel"}, 64'(out_wsel), 64'(e.wsel));
    check({tag, ".out_wen"}, 64'(out_wen), 64'(e.wen));
    check({tag, ".out_exc"}, 64'(out_exc), 64'(e.exc));
  endtask

  // One clock: drive at negedge, check, update model, advance to next negedge.
  task automatic step(input string tag, input logic iv, input stim_t s,
                      input logic ordy, input logic fl);
    exp_t e;
    int   n;
    in_valid  = iv;
    port_out  = s.res;
    negative  = s.neg;
    zero      = s.zer;
    overflow  = s.ovf;
    ov_trap   = s.trap;
    wsel      = s.wsel;
    wen       = s.wen;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(tag);
    n = exp_q.size();
    if (fl) begin
      exp_q.delete();
    end else begin
      if (ordy && n > 0) void'(exp_q.pop_front());
      if (iv && n < 2) begin
        e.res  = s.res;
        e.neg  = s.neg;
        e.zer  = s.zer;
        e.ovf  = s.ovf;
        e.wsel = s.wsel;
        e.exc  = s.ovf & s.trap;
        e.wen  = s.wen & ~(s.ovf & s.trap);
        exp_q.push_back(e);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.delete();
  endtask

  stim_t idle;

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    idle = mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    nRST = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    port_out = 32'd0; negative = 1'b0; zero = 1'b0; overflow = 1'b0;
    ov_trap = 1'b0; wsel = 5'd0; wen = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.delete();
    step("reset", 1'b0, idle, 1'b1, 1'b0);

    // Single pass
    step("single.push", 1'b1, mk(32'h5, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
    step("single.out",  1'b0, idle, 1'b1, 1'b0);
    step("single.empty", 1'b0, idle, 1'b1, 1'b0);

    // Fill and backpressure; third push is ignored
    step("fill.a", 1'b1, mk(32'hA, 5'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("fill.b", 1'b1, mk(32'hB, 5'd2, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("fill.c", 1'b1, mk(32'hC, 5'd4, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("fill.hold", 1'b0, idle, 1'b0, 1'b0);
    step("fill.pa", 1'b0, idle, 1'b1, 1'b0);
    step("fill.pb", 1'b0, idle, 1'b1, 1'b0);
    step("fill.empty", 1'b0, idle, 1'b1, 1'b0);

    // Simultaneous push and pop at count 1
    step("sim.p1", 1'b1, mk(32'h1, 5'd5, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("sim.p2", 1'b1, mk(32'h2, 5'd6, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
    step("sim.h2", 1'b0, idle, 1'b1, 1'b0);
    step("sim.empty", 1'b0, idle, 1'b1, 1'b0);

    // Trap masking with and without ov_trap
    step("trap.t1", 1'b1, mk(32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
    step("trap.t0", 1'b1, mk(32'h8000_0000, 5'd8, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step("trap.o1", 1'b0, idle, 1'b1, 1'b0);
    step("trap.o0", 1'b0, idle, 1'b1, 1'b0);
    step("trap.empty", 1'b0, idle, 1'b0, 1'b0);

    // Flush at full with simultaneous push and pop
    step("flush.f1", 1'b1, mk(32'h11, 5'd9, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("flush.f2", 1'b1, mk(32'h22, 5'd10, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    step("flush.go", 1'b1, mk(32'h33, 5'd11, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
    step("flush.after", 1'b0, idle, 1'b1, 1'b0);

    // Reset mid-stream, then a push one cycle after release
    step("rst.f1", 1'b1, mk(32'h44, 5'd12, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("rst.f2", 1'b1, mk(32'h55, 5'd13, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b1; flush = 1'b0;
    do_reset();
    step("rst.after", 1'b1, mk(32'h66, 5'd14, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step("rst.push", 1'b0, idle, 1'b1, 1'b0);
    step("rst.empty", 1'b0, idle, 1'b0, 1'b0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)),
           mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
